// File: rtl/zbus_pkg.sv
// Shared zbus definitions: arbitration modes, ownership state and a
// constant-evaluable clog2 for sizing port index fields.
package zbus_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } zbus_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/zbus_arb_pick.sv
// Combinational winner select over a request vector, either by a priority
// table (slot 0 highest) or round robin starting at a base pointer.
module zbus_arb_pick import zbus_pkg::*; #(
  parameter int BN   = 4,
  parameter int BNL  = clog2(BN),
  parameter int MODE = MODE_FIXED
) (
  input  logic [BN-1:0]     i_req,
  input  logic [BNL-1:0]    i_base,
  input  logic [BNL*BN-1:0] i_prio,
  output logic [BN-1:0]     o_gnt,
  output logic [BNL-1:0]    o_idx,
  output logic              o_any
);

  logic [BNL-1:0] w_cand;

  // Scan candidates in priority order; the first requesting one wins.
  always_comb begin
    w_cand = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int k = 0; k < BN; k++) begin
      if (MODE == MODE_FIXED) begin
        w_cand = i_prio[k*BNL +: BNL];
      end else begin
        w_cand = BNL'((int'(i_base) + k) % BN);
      end
      if (i_req[w_cand] && !o_any) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end else begin
        o_idx = o_idx;
        o_any = o_any;
      end
    end
    if (o_any) begin
      o_gnt = BN'(1) << o_idx;
    end else begin
      o_gnt = '0;
    end
  end

endmodule

// File: rtl/zbus_arb.sv
// N-to-1 zbus arbiter/mux with lock-based ownership, fixed-priority or
// round-robin selection, and an optional registered output slot.
module zbus_arb import zbus_pkg::*; #(
  parameter int BW   = 32,
  parameter int BN   = 4,
  parameter int BNL  = clog2(BN),
  parameter int MODE = MODE_FIXED,
  parameter int REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BN-1:0]     zi_vld,
  input  logic [BN-1:0]     zi_lck,
  input  logic [BW*BN-1:0]  zi_bus,
  output logic [BN-1:0]     zi_ack,
  output logic              zo_vld,
  output logic              zo_lck,
  output logic [BW-1:0]     zo_bus,
  input  logic              zo_ack,
  input  logic [BNL*BN-1:0] prio,
  output logic [BNL-1:0]    owner
);

  zbus_state_e    r_state;
  zbus_state_e    w_state_nxt;
  logic [BNL-1:0] r_own_idx;
  logic [BNL-1:0] r_rr_ptr;
  logic           r_full;
  logic           r_slot_lck;
  logic [BW-1:0]  r_slot_bus;

  logic [BN-1:0]  w_pick_gnt;
  logic [BNL-1:0] w_pick_idx;
  logic           w_pick_any;
  logic [BN-1:0]  w_gnt_oh;
  logic [BNL-1:0] w_g;
  logic [BNL-1:0] w_rr_nxt;
  logic           w_gnt_vld;
  logic           w_g_vld;
  logic           w_g_lck;
  logic [BW-1:0]  w_g_bus;
  logic           w_hs_ack;
  logic           w_xfer;

  zbus_arb_pick #(
    .BN   (BN),
    .BNL  (BNL),
    .MODE (MODE)
  ) u_pick (
    .i_req  (zi_vld),
    .i_base (r_rr_ptr),
    .i_prio (prio),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // While owned the owner is granted even with vld low, so a lock can be
  // released without a transfer.
  always_comb begin
    w_gnt_vld = (r_state == OWNED) || w_pick_any;
    if (r_state == OWNED) begin
      w_g      = r_own_idx;
      w_gnt_oh = BN'(1) << r_own_idx;
    end else begin
      w_g      = w_pick_idx;
      w_gnt_oh = w_pick_gnt;
    end
    w_g_vld = w_gnt_vld & zi_vld[w_g];
    w_g_lck = w_gnt_vld & zi_lck[w_g];
    if (w_gnt_vld) begin
      w_g_bus = zi_bus[w_g*BW +: BW];
    end else begin
      w_g_bus = '0;
    end
    if (REG != 0) begin
      w_hs_ack = w_g_vld & (~r_full | zo_ack);
    end else begin
      w_hs_ack = w_gnt_vld & zo_ack;
    end
    w_xfer = w_g_vld & w_hs_ack;
    if (w_hs_ack) begin
      zi_ack = w_gnt_oh;
    end else begin
      zi_ack = '0;
    end
    if (w_g == BNL'(BN - 1)) begin
      w_rr_nxt = '0;
    end else begin
      w_rr_nxt = w_g + BNL'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_g_vld && (!w_hs_ack || w_g_lck)) begin
          w_state_nxt = OWNED;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      OWNED: begin
        if ((w_g_vld && w_hs_ack && !w_g_lck) || (!w_g_vld && !w_g_lck)) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = OWNED;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_own_idx  <= '0;
      r_rr_ptr   <= '0;
      r_full     <= 1'b0;
      r_slot_lck <= 1'b0;
      r_slot_bus <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_vld) begin
        r_own_idx <= w_g;
      end
      // Lock chains move the pointer only on their final, unlocked beat.
      if (w_xfer && !w_g_lck) begin
        r_rr_ptr <= w_rr_nxt;
      end
      if (w_xfer) begin
        r_full     <= 1'b1;
        r_slot_lck <= w_g_lck;
        r_slot_bus <= w_g_bus;
      end else if (zo_ack) begin
        r_full <= 1'b0;
      end
    end
  end

  always_comb begin
    if (REG != 0) begin
      zo_vld = r_full;
      zo_lck = r_slot_lck;
      zo_bus = r_slot_bus;
    end else begin
      zo_vld = w_g_vld;
      zo_lck = w_g_lck;
      zo_bus = w_g_bus;
    end
  end

  assign owner = r_own_idx;

endmodule

// File: tb/tb_zbus_arb.sv
// Directed bench for zbus_arb: fixed-priority, round-robin and registered
// instances driven through a linear sequence of hand-computed steps.
module tb_zbus_arb;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] prio;
  int total = 0;
  int bad   = 0;

  logic [3:0]   fx_vld, fx_lck, fx_ack, rr_vld, rr_lck, rr_ack, rg_vld, rg_lck, rg_ack;
  logic [127:0] fx_bus, rr_bus, rg_bus;
  logic         fx_zo_vld, fx_zo_lck, fx_zo_ack, rr_zo_vld, rr_zo_lck, rr_zo_ack;
  logic         rg_zo_vld, rg_zo_lck, rg_zo_ack;
  logic [31:0]  fx_zo_bus, rr_zo_bus, rg_zo_bus;
  logic [1:0]   fx_owner, rr_owner, rg_owner;

  always #5 clk = ~clk;

  zbus_arb #(.BW(32), .BN(4), .MODE(0), .REG(0)) u_fx (
    .clk(clk), .rst(rst), .zi_vld(fx_vld), .zi_lck(fx_lck), .zi_bus(fx_bus),
    .zi_ack(fx_ack), .zo_vld(fx_zo_vld), .zo_lck(fx_zo_lck), .zo_bus(fx_zo_bus),
    .zo_ack(fx_zo_ack), .prio(prio), .owner(fx_owner));

  zbus_arb #(.BW(32), .BN(4), .MODE(1), .REG(0)) u_rr (
    .clk(clk), .rst(rst), .zi_vld(rr_vld), .zi_lck(rr_lck), .zi_bus(rr_bus),
    .zi_ack(rr_ack), .zo_vld(rr_zo_vld), .zo_lck(rr_zo_lck), .zo_bus(rr_zo_bus),
    .zo_ack(rr_zo_ack), .prio(prio), .owner(rr_owner));

  zbus_arb #(.BW(32), .BN(4), .MODE(0), .REG(1)) u_rg (
    .clk(clk), .rst(rst), .zi_vld(rg_vld), .zi_lck(rg_lck), .zi_bus(rg_bus),
    .zi_ack(rg_ack), .zo_vld(rg_zo_vld), .zo_lck(rg_zo_lck), .zo_bus(rg_zo_bus),
    .zo_ack(rg_zo_ack), .prio(prio), .owner(rg_owner));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    prio = {2'd3, 2'd2, 2'd1, 2'd0};
    fx_vld = 4'b0000; fx_lck = 4'b0000; fx_zo_ack = 1'b0;
    rr_vld = 4'b0000; rr_lck = 4'b0000; rr_zo_ack = 1'b0;
    rg_vld = 4'b0000; rg_lck = 4'b0000; rg_zo_ack = 1'b0;
    fx_bus = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    rr_bus = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    rg_bus = 128'h0;
    tick(); tick();
    #2;
    chk("rst_ack", 64'(fx_ack), 64'h0);
    chk("rst_zo_vld", 64'(fx_zo_vld), 64'h0);
    chk("rst_zo_bus", 64'(fx_zo_bus), 64'h0);
    chk("rst_owner", 64'(fx_owner), 64'h0);
    chk("rst_rg_vld", 64'(rg_zo_vld), 64'h0);
    rst = 1'b0;
    tick();

    // Fixed priority
    fx_vld = 4'b1010; fx_zo_ack = 1'b1; #2;
    chk("fix_ack_a", 64'(fx_ack), 64'h2);
    chk("fix_bus_a", 64'(fx_zo_bus), 64'hBBBB_0001);
    chk("fix_vld_a", 64'(fx_zo_vld), 64'h1);
    tick();
    fx_vld = 4'b1000; #2;
    chk("fix_ack_b", 64'(fx_ack), 64'h8);
    chk("fix_bus_b", 64'(fx_zo_bus), 64'hDDDD_0003);
    chk("fix_owner_b", 64'(fx_owner), 64'h1);
    tick();
    fx_vld = 4'b0000; tick();

    // Backpressure
    fx_vld = 4'b0010; fx_zo_ack = 1'b0; #2;
    chk("bp_ack_0", 64'(fx_ack), 64'h0);
    chk("bp_bus_0", 64'(fx_zo_bus), 64'hBBBB_0001);
    tick();
    fx_vld = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("bp_ack_hold", 64'(fx_ack), 64'h0);
      chk("bp_bus_hold", 64'(fx_zo_bus), 64'hBBBB_0001);
      tick();
    end
    fx_zo_ack = 1'b1; #2;
    chk("bp_ack_done", 64'(fx_ack), 64'h2);
    tick();
    fx_vld = 4'b0001; #2;
    chk("bp_next_ack", 64'(fx_ack), 64'h1);
    chk("bp_next_bus", 64'(fx_zo_bus), 64'hAAAA_0000);
    tick();
    fx_vld = 4'b0000; tick();

    // Lock chain: port 2 holds ownership for three beats
    fx_vld = 4'b0100; fx_lck = 4'b0100; #2;
    chk("lk_ack_1", 64'(fx_ack), 64'h4);
    tick();
    fx_vld = 4'b0101; #2;
    chk("lk_ack_2", 64'(fx_ack), 64'h4);
    chk("lk_zo_lck", 64'(fx_zo_lck), 64'h1);
    tick();
    #2;
    chk("lk_ack_3", 64'(fx_ack), 64'h4);
    chk("lk_owner", 64'(fx_owner), 64'h2);
    tick();
    fx_vld = 4'b0001; fx_lck = 4'b0000; fx_zo_ack = 1'b0; #2;
    chk("lk_release", 64'(fx_ack), 64'h0);
    tick();
    fx_zo_ack = 1'b1; #2;
    chk("lk_port0", 64'(fx_ack), 64'h1);
    tick();
    fx_vld = 4'b0000; tick();

    // Round robin fairness
    rr_vld = 4'b1111; rr_zo_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("rr_ack", 64'(rr_ack), 64'(4'b0001 << (i % 4)));
      chk("rr_bus", 64'(rr_zo_bus), 64'(rr_bus[(i % 4)*32 +: 32]));
      tick();
    end
    rr_vld = 4'b0000; #2;
    chk("rr_owner", 64'(rr_owner), 64'h0);
    tick();
    rr_vld = 4'b1001; #2;
    chk("rr_ptr_wrap", 64'(rr_ack), 64'h8);
    tick();
    rr_vld = 4'b0000; tick();

    // Registered output stream
    rg_zo_ack = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 8) begin
        rg_vld = 4'b0001;
        rg_bus[31:0] = 32'h1000_0000 + 32'(c);
      end else begin
        rg_vld = 4'b0000;
      end
      #2;
      chk("rg_ack", 64'(rg_ack), (c < 8) ? 64'h1 : 64'h0);
      chk("rg_zo_vld", 64'(rg_zo_vld), (c > 0) ? 64'h1 : 64'h0);
      if (c > 0) begin
        chk("rg_zo_bus", 64'(rg_zo_bus), 64'(32'h1000_0000 + 32'(c - 1)));
      end
      tick();
    end
    rg_vld = 4'b0001; rg_bus[31:0] = 32'h1000_0008; rg_zo_ack = 1'b0; #2;
    chk("rg_fill_ack", 64'(rg_ack), 64'h1);
    chk("rg_empty", 64'(rg_zo_vld), 64'h0);
    tick();
    rg_bus[31:0] = 32'h1000_0009; #2;
    chk("rg_stall_ack", 64'(rg_ack), 64'h0);
    chk("rg_stall_bus", 64'(rg_zo_bus), 64'h1000_0008);
    tick();
    rg_zo_ack = 1'b1; #2;
    chk("rg_resume_ack", 64'(rg_ack), 64'h1);
    tick();
    rg_vld = 4'b0000; #2;
    chk("rg_last_bus", 64'(rg_zo_bus), 64'h1000_0009);
    tick();

    // Reset while port 3 owns with lock
    fx_vld = 4'b1000; fx_lck = 4'b1000;
    rg_vld = 4'b0001; rg_bus[31:0] = 32'h2222_0000; rg_zo_ack = 1'b0; #2;
    chk("ml_ack_3", 64'(fx_ack), 64'h8);
    tick();
    rg_vld = 4'b0000;
    fx_vld = 4'b1010; rst = 1'b1; #2;
    chk("ml_owned_ack", 64'(fx_ack), 64'h8);
    chk("ml_rg_full", 64'(rg_zo_vld), 64'h1);
    tick();
    fx_vld = 4'b0000; fx_lck = 4'b0000; #2;
    chk("ml_rst_ack", 64'(fx_ack), 64'h0);
    chk("ml_rst_vld", 64'(fx_zo_vld), 64'h0);
    chk("ml_rst_lck", 64'(fx_zo_lck), 64'h0);
    chk("ml_rst_bus", 64'(fx_zo_bus), 64'h0);
    chk("ml_rst_owner", 64'(fx_owner), 64'h0);
    chk("ml_rg_drop", 64'(rg_zo_vld), 64'h0);
    chk("ml_rg_bus", 64'(rg_zo_bus), 64'h0);
    tick();
    rst = 1'b0;
    fx_vld = 4'b1010; fx_lck = 4'b1000; fx_zo_ack = 1'b1; #2;
    chk("ml_after_ack", 64'(fx_ack), 64'h2);
    chk("ml_after_bus", 64'(fx_zo_bus), 64'hBBBB_0001);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zbus_arb.md
# zbus_arb

Parametrised N-to-1 zbus arbiter and multiplexer with fixed-priority or round-robin arbitration, lock-based bus ownership, and an optional registered output stage. It sits between several zbus masters and one zbus slave port, for example in front of a shared memory controller. It is the next generation of the simple priority mux, with proper ownership tracking and fairness.

## Interface
- BW, 32: bus payload width (grouped address/data/control), ≥1
- BN, 4: number of input ports, 2..16
- BNL, clog2(BN): port index width
- MODE, 0: 0 = fixed priority from `priority`; 1 = round robin
- REG, 0: 0 = combinational output path; 1 = one registered pipeline stage on the output
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- zi_vld  in  BN  per-port transfer valid
- zi_lck  in  BN  per-port lock request (keep ownership after the current transfer)
- zi_bus  in  BW*BN  per-port payload; port i is at [i*BW +: BW]
- zi_ack  out  BN  per-port acknowledge; one-hot or zero
- zo_vld  out  1  output transfer valid
- zo_lck  out  1  lock of the current output transfer
- zo_bus  out  BW  output payload
- zo_ack  in  1  output acknowledge from the slave
- priority  in  BNL*BN  slot k holds the port index of priority k; slot 0 is highest; MODE 0 only; must be a permutation
- owner  out  BNL  index of the current or last owner (debug)

## Operation
- Transfer: occurs on a side when vld & ack are both high in the same cycle. A master holds vld and bus stable until it receives ack.
- State: `owned` (1 bit), `own_idx` (BNL), `rr_ptr` (BNL, MODE 1 only).
- **IDLE (owned=0)**: the grant goes to the winning requester among zi_vld.
  - MODE 0: winner is the lowest slot k with zi_vld[priority[k]].
  - MODE 1: winner is the first requester at or after rr_ptr, wrapping from BN-1 to 0.
- **OWNED (owned=1)**: the grant goes to own_idx only. All other ports see zi_ack=0, even if they are valid.
- **Transitions** (REG=0, evaluated on the granted port g):
  - IDLE→OWNED: when zi_vld[g] & (~zo_ack | zi_lck[g]).
  - OWNED→IDLE: when zi_vld[g] & zo_ack & ~zi_lck[g], or when ~zi_vld[g] & ~zi_lck[g]. The second case is a lock released without a transfer.
  - While OWNED, lck held high keeps ownership across any number of transfers.
- **rr_ptr**: set to g+1 (mod BN) on every completed transfer whose lck is 0. Lock chains advance the pointer only when they end.
- **Outputs (REG=0)**:
  - zo_vld/zo_lck/zo_bus equal the granted port's signals.
  - With no grant: zo_vld=0, zo_lck=0, zo_bus=0.
  - zi_ack[g] = zo_ack.
- **REG=1**: one output register slot (full flag).
  - zi_ack[g] = zi_vld[g] & (~full | zo_ack).
  - On a load, the slot captures vld/lck/bus.
  - zo_* are driven from the slot; zo_vld = full.
  - Ownership transitions apply to the input-side handshake, with zi_ack replacing zo_ack in the rules above.
- **owner**: equals own_idx when OWNED, otherwise the last granted port.
- **Errors/edge cases**:
  - Changing `priority` while OWNED has no effect until IDLE.
  - A non-permutation `priority` is unsupported.
  - A port that drops vld mid-transfer is a protocol error. The arbiter still follows the release rules above.

## Timing
- Reset values: owned=0, own_idx=0, rr_ptr=0, owner=0, full=0, zo_vld=0, zo_lck=0, zo_bus=0, zi_ack=0.
- REG=0: zero-cycle latency from zi to zo, with a combinational path zo_ack→zi_ack.
- REG=1: one-cycle latency from zi to zo. Full throughput is one transfer per cycle while zo_ack stays high.
- There is no idle cycle between owners. A new winner is granted in the cycle after OWNED→IDLE, or in the same cycle when the previous transfer completed from IDLE.
- Simultaneous requests are resolved in one cycle. Losers keep vld high and are served in later arbitration rounds.
- Reset asserted mid-transfer: all state clears on the next edge. An in-flight slot (REG=1) is dropped.

## Structure
- Shared package `zbus_pkg`:
  - MODE_FIXED/MODE_RR constants
  - a state enum {IDLE, OWNED}
  - a clog2 helper function
- Sub-module `zbus_arb_pick`: combinational priority/round-robin winner select (req, base pointer, or priority table → one-hot grant plus index). It is reusable by future zbus interconnect blocks.

## Test plan
- **Fixed priority**: MODE 0, priority={3,2,1,0} (slot0=0); zi_vld=4'b1010, zo_ack=1 → port 1 granted and zi_ack=4'b0010; next cycle zi_vld=4'b1000 → port 3 granted.
- **Round robin fairness**: MODE 1, all four ports valid, zo_ack=1 → grants 0,1,2,3,0 on consecutive cycles; rr_ptr wraps 3→0.
- **Lock chain**: port 2 raises lck for 3 transfers while port 0 is also valid → port 2 gets 3 acks with no intervening grant to port 0; port 0 is granted in the cycle after port 2's lck drops.
- **Backpressure**: zo_ack=0 for 5 cycles with port 1 valid → zo_bus stays equal to port 1's payload; port 0 raising vld meanwhile gets no ack; the transfer completes when zo_ack rises.
- **REG=1 throughput**: stream 8 beats from port 0 with zo_ack=1 → 8 zo transfers, 1-cycle offset, no bubbles. Then zo_ack=0 → zi_ack drops after the slot fills.
- **Reset mid-lock**: assert rst while port 3 owns with lck=1 → next cycle owned=0 and all outputs at their reset values; after rst falls, the lowest requester wins.
